// File: rtl/softmax_sequencer_pkg.sv
// softmax_sequencer_pkg: shared FSM encoding and Q11.20 defaults for the softmax sequencer.
package softmax_sequencer_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int FRACTION_BITS  = 20;
    localparam int DEF_DATA_NUM   = 10;
    localparam logic [31:0] ONE   = 32'd1 << FRACTION_BITS;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4,
        RESULT    = 3'd5
    } state_t;
endpackage

// File: rtl/softmax_sequencer_logit_buffer.sv
// logit_buffer: DATA_NUM x DATA_WIDTH logit store, synchronous write, asynchronous read.
// Ports: clk; wr_en/wr_adr/wr_data write port; rd_adr/rd_data combinational read port
// (reads at or beyond DATA_NUM return 0). Contents are not reset.
module logit_buffer
    import softmax_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DATA_NUM   = DEF_DATA_NUM,
    parameter int ADR_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADR_WIDTH-1:0]  wr_adr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADR_WIDTH-1:0]  rd_adr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [DATA_NUM];
    logic                  rd_in_range;

    assign rd_in_range = {1'b0, rd_adr} < (ADR_WIDTH + 1)'(DATA_NUM);
    assign rd_data     = rd_in_range ? mem[rd_adr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_adr] <= wr_data;
    end
endmodule

// File: rtl/softmax_sequencer.sv
// softmax_sequencer: collects a frame of logits, kicks the softmax engine, tracks the argmax
// of the returned probabilities and presents the winning class and probability.
// Ports: clk, rst_n (async, active-low);
//   s_valid/s_ready/s_data/s_last  logit input stream;
//   sm_start/sm_done               engine start pulse and idle level;
//   sm_adrIn/sm_dataIn             engine read port into the logit buffer;
//   sm_adrOut/sm_dataOut/sm_wr     engine probability writes;
//   m_valid/m_ready/m_class/m_prob result handshake;
//   busy (not IDLE), err_len (sticky frame-length error).
module softmax_sequencer
    import softmax_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DATA_NUM   = DEF_DATA_NUM,
    parameter int ADR_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  sm_start,
    input  logic                  sm_done,
    input  logic [ADR_WIDTH-1:0]  sm_adrIn,
    output logic [DATA_WIDTH-1:0] sm_dataIn,
    input  logic [ADR_WIDTH-1:0]  sm_adrOut,
    input  logic [DATA_WIDTH-1:0] sm_dataOut,
    input  logic                  sm_wr,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADR_WIDTH-1:0]  m_class,
    output logic [DATA_WIDTH-1:0] m_prob,
    output logic                  busy,
    output logic                  err_len
);
    localparam logic [ADR_WIDTH-1:0] LAST_IDX = ADR_WIDTH'(DATA_NUM - 1);

    state_t                state_q, state_d;
    logic [ADR_WIDTH-1:0]  count_q, count_d;
    logic [ADR_WIDTH-1:0]  best_class_q, best_class_d;
    logic [DATA_WIDTH-1:0] best_prob_q, best_prob_d;
    logic                  err_len_q, err_len_d;
    logic                  s_ready_q, sm_start_q, m_valid_q, busy_q;
    logic                  accept, at_last, argmax_win;
    logic [ADR_WIDTH-1:0]  wr_adr;

    assign accept     = s_valid & s_ready_q;
    assign wr_adr     = (state_q == IDLE) ? '0 : count_q;
    assign at_last    = (state_q == IDLE) ? (DATA_NUM == 1) : (count_q == LAST_IDX);
    // strict compare keeps the earliest writer on ties and leaves class 0 for an all-zero frame
    assign argmax_win = sm_wr && (state_q == WAIT_BUSY || state_q == WAIT_DONE)
                        && (sm_dataOut > best_prob_q);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        err_len_d    = err_len_q;
        best_prob_d  = argmax_win ? sm_dataOut : best_prob_q;
        best_class_d = argmax_win ? sm_adrOut : best_class_q;
        case (state_q)
            IDLE, LOAD: if (accept) begin
                count_d   = wr_adr + 1'b1;
                // the first word of a frame drops the previous frame's error
                err_len_d = (state_q == LOAD && err_len_q) | (at_last ? !s_last : s_last);
                state_d   = at_last ? START : LOAD;
            end
            START: begin
                best_prob_d  = '0;
                best_class_d = '0;
                state_d      = WAIT_BUSY;
            end
            WAIT_BUSY: state_d = sm_done ? WAIT_BUSY : WAIT_DONE;
            WAIT_DONE: state_d = sm_done ? RESULT : WAIT_DONE;
            RESULT:    state_d = m_ready ? IDLE : RESULT;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            best_prob_q  <= '0;
            best_class_q <= '0;
            err_len_q    <= 1'b0;
            s_ready_q    <= 1'b0;
            sm_start_q   <= 1'b0;
            m_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            best_prob_q  <= best_prob_d;
            best_class_q <= best_class_d;
            err_len_q    <= err_len_d;
            s_ready_q    <= (state_d == IDLE) || (state_d == LOAD);
            sm_start_q   <= (state_d == START);
            m_valid_q    <= (state_d == RESULT);
            busy_q       <= (state_d != IDLE);
        end
    end

    assign s_ready  = s_ready_q;
    assign sm_start = sm_start_q;
    assign m_valid  = m_valid_q;
    assign busy     = busy_q;
    assign err_len  = err_len_q;
    assign m_class  = best_class_q;
    assign m_prob   = best_prob_q;

    logit_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_NUM   (DATA_NUM),
        .ADR_WIDTH  (ADR_WIDTH)
    ) u_buf (
        .clk     (clk),
        .wr_en   (accept),
        .wr_adr  (wr_adr),
        .wr_data (s_data),
        .rd_adr  (sm_adrIn),
        .rd_data (sm_dataIn)
    );
endmodule

// File: tb/tb_softmax_sequencer.sv
// tb_softmax_sequencer: randomized scoreboard bench with a behavioural softmax engine.
module tb_softmax_sequencer;
    localparam int DW = 32;
    localparam int DN = 10;
    localparam int AW = 4;
    localparam logic [DW-1:0] P01 = 32'h19999;
    localparam logic [DW-1:0] P03 = 32'h4CCCC;

    typedef logic [DN-1:0][DW-1:0] frame_t;
    typedef struct {
        logic [AW-1:0] cls;
        logic [DW-1:0] prob;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid, s_ready, s_last;
    logic [DW-1:0] s_data;
    logic          sm_start, sm_done, sm_wr;
    logic [AW-1:0] sm_adrIn, sm_adrOut;
    logic [DW-1:0] sm_dataIn, sm_dataOut;
    logic          m_valid, m_ready;
    logic [AW-1:0] m_class;
    logic [DW-1:0] m_prob;
    logic          busy, err_len;

    softmax_sequencer #(.DATA_WIDTH(DW), .DATA_NUM(DN), .ADR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .sm_start(sm_start), .sm_done(sm_done),
        .sm_adrIn(sm_adrIn), .sm_dataIn(sm_dataIn),
        .sm_adrOut(sm_adrOut), .sm_dataOut(sm_dataOut), .sm_wr(sm_wr),
        .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class), .m_prob(m_prob),
        .busy(busy), .err_len(err_len)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_fails = 0;
    int     cyc = 0;
    int     acc_cyc = 0;
    int     start_exp = 0;
    int     done_cyc = 0;
    int     start_cnt = 0;
    int     results = 0;
    int     frames_sent = 0;
    int     rdy_mode = 0;
    logic   prev_err = 1'b0;
    exp_t   sb_q[$];
    frame_t logit_q[$];
    frame_t prob_q[$];
    int     hs_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: the winner is the largest probability, lowest index among equals.
    function automatic exp_t model(input frame_t p, input logic err);
        exp_t e;
        logic [DW-1:0] mx = '0;
        foreach (p[i]) mx = (p[i] > mx) ? p[i] : mx;
        e.cls = '0;
        for (int i = DN - 1; i >= 0; i--) if (p[i] == mx) e.cls = AW'(i);
        e.prob = mx;
        e.err  = err;
        return e;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        foreach (f[i]) f[i] = $urandom;
        return f;
    endfunction

    function automatic frame_t rand_probs();
        frame_t f;
        int kind = $urandom_range(0, 3);
        foreach (f[i]) begin
            case (kind)
                0:       f[i] = $urandom;
                1:       f[i] = DW'($urandom_range(0, 3));
                2:       f[i] = '0;
                default: f[i] = DW'($urandom_range(0, 32'hFFFFF));
            endcase
        end
        if (kind == 3) begin
            f[$urandom_range(0, DN - 1)] = 32'h100000;
            f[$urandom_range(0, DN - 1)] = 32'h100000;
        end
        return f;
    endfunction

    task automatic send_word(input logic [DW-1:0] d, input logic last);
        int   n = 0;
        logic got;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        do begin
            @(negedge clk);
            got     = s_ready;
            acc_cyc = cyc;
            @(posedge clk);
            n++;
            if (n > 5000) begin
                n_fails++;
                $display("FAIL send_word: s_ready never asserted");
                $fatal(1, "stimulus timeout");
            end
        end while (!got);
        #1 s_valid = 1'b0;
    endtask

    task automatic send_frame(input frame_t lg, input frame_t pr, input int last_pos,
                              input int gap_max, output int first_acc);
        logic err = (last_pos != DN - 1);
        check("err_len_sticky", err_len, prev_err);
        first_acc = 0;
        for (int i = 0; i < DN; i++) begin
            send_word(lg[i], i == last_pos);
            if (i == 0) begin
                first_acc = acc_cyc;
                check("err_len_first_word", err_len, last_pos == 0);
            end
            if (i == DN - 1) begin
                logit_q.push_back(lg);
                prob_q.push_back(pr);
                sb_q.push_back(model(pr, err));
                start_exp = acc_cyc + 1;
                frames_sent++;
            end else if (gap_max > 0) begin
                int k = $urandom_range(0, gap_max);
                if (k > 0) begin
                    repeat (k) @(posedge clk);
                    #1;
                end
            end
        end
        prev_err = err;
    endtask

    task automatic wait_results(input int target);
        int n = 0;
        while (results < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("results_count", results, target);
    endtask

    // Behavioural softmax engine: reads the logits back, writes probabilities in index order.
    initial begin
        sm_done = 1'b1; sm_wr = 1'b0; sm_adrIn = '0; sm_adrOut = '0; sm_dataOut = '0;
        forever begin
            @(negedge clk);
            if (rst_n && sm_start) begin : engine
                frame_t p, lg;
                bit     concur;
                if (prob_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL engine_frame: sm_start with no frame queued");
                end else begin
                    p = prob_q.pop_front();
                    lg = logit_q.pop_front();
                    concur = 1'($urandom % 2);
                    @(posedge clk); #1;
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    sm_done = 1'b0;
                    for (int i = 0; i < DN; i++) begin
                        sm_adrIn = AW'(i); sm_wr = 1'b1; sm_adrOut = AW'(i); sm_dataOut = p[i];
                        if (i == DN - 1 && concur) begin sm_done = 1'b1; done_cyc = cyc; end
                        @(negedge clk);
                        check("sm_dataIn", sm_dataIn, lg[i]);
                        @(posedge clk); #1;
                        sm_wr = 1'b0;
                        if ($urandom % 4 == 0) begin @(posedge clk); #1; end
                    end
                    if (!concur) begin
                        sm_done = 1'b1;
                        done_cyc = cyc;
                        @(posedge clk); #1;
                    end
                    sm_wr = 1'b1; sm_adrOut = AW'(3); sm_dataOut = '1;
                    sm_adrIn = AW'($urandom_range(DN, 2 ** AW - 1));
                    @(negedge clk);
                    check("sm_dataIn_out_of_range", sm_dataIn, 0);
                    @(posedge clk); #1;
                    sm_wr = 1'b0;
                end
            end
        end
    end

    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            m_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom % 2) : 1'b0;
        end
    end

    // Monitor: compares every presented result against the scoreboard head.
    initial begin
        logic prev_start = 1'b0, prev_mv = 1'b0, hs_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_start = 1'b0; prev_mv = 1'b0; hs_pending = 1'b0;
            end else begin
                if (hs_pending) check("s_ready_after_handshake", s_ready, 1);
                hs_pending = 1'b0;
                if (sm_start) begin
                    start_cnt++;
                    check("sm_start_pulse_width", prev_start, 0);
                    check("sm_start_latency", cyc, start_exp);
                end
                if (m_valid) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fails++;
                        $display("FAIL m_valid: result with empty scoreboard (cycle %0d)", cyc);
                    end else begin
                        if (!prev_mv) check("m_valid_latency", cyc, done_cyc + 1);
                        check("m_class", m_class, sb_q[0].cls);
                        check("m_prob", m_prob, sb_q[0].prob);
                        check("s_ready_in_result", s_ready, 0);
                        if (m_ready) begin
                            check("err_len", err_len, sb_q[0].err);
                            void'(sb_q.pop_front());
                            hs_cyc_q.push_back(cyc);
                            hs_pending = 1'b1;
                            results++;
                        end
                    end
                end
                prev_start = sm_start;
                prev_mv = m_valid;
            end
        end
    end

    initial begin
        #500000;
        n_fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f_lg, f_pr, f_lg2, f_pr2;
        int     fa, fa2, n, r0, sc, lp;
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_sm_start", sm_start, 0);
        check("rst_err_len", err_len, 0);
        check("rst_m_class", m_class, 0);
        check("rst_m_prob", m_prob, 0);
        rst_n = 1'b1;
        check("s_ready_before_first_edge", s_ready, 0);
        @(negedge clk);
        check("s_ready_after_reset", s_ready, 1);
        @(posedge clk); #1;

        foreach (f_lg[i]) f_lg[i] = DW'(i) << 20;
        foreach (f_pr[i]) f_pr[i] = DW'((i + 1) * 32'h1000);
        send_frame(f_lg, f_pr, DN - 1, 0, fa);
        wait_results(1);
        check("single_start_pulse", start_cnt, 1);
        check("ramp_class_is_9", model(f_pr, 1'b0).cls, 9);

        foreach (f_pr[i]) f_pr[i] = P01;
        f_pr[1] = P03;
        f_pr[2] = P03;
        @(posedge clk); #1;
        send_frame(f_lg, f_pr, DN - 1, 1, fa);
        wait_results(2);

        @(posedge clk); #1;
        send_frame(rand_frame(), rand_probs(), 4, 1, fa);
        wait_results(3);

        rdy_mode = 2;
        @(posedge clk); #1;
        send_frame(rand_frame(), rand_probs(), DN - 1, 0, fa);
        n = 0;
        while (!m_valid && n < 2000) begin @(negedge clk); n++; end
        check("hold_m_valid_reached", m_valid, 1);
        repeat (20) begin
            @(negedge clk);
            check("hold_m_valid", m_valid, 1);
        end
        rdy_mode = 0;
        wait_results(4);

        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) send_word($urandom, 1'b0);
        sc = start_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_m_valid", m_valid, 0);
        check("midrst_s_ready", s_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        prev_err = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_no_start", start_cnt, sc);
        check("midrst_no_result", results, 4);
        @(posedge clk); #1;
        send_frame(rand_frame(), rand_probs(), DN - 1, 1, fa);
        wait_results(5);

        r0 = results;
        @(posedge clk); #1;
        f_lg = rand_frame(); f_pr = rand_probs(); f_lg2 = rand_frame(); f_pr2 = rand_probs();
        send_frame(f_lg, f_pr, DN - 1, 0, fa);
        send_frame(f_lg2, f_pr2, DN - 1, 0, fa2);
        wait_results(r0 + 2);
        check("b2b_first_word_after_handshake", fa2, hs_cyc_q[r0] + 1);

        rdy_mode = 1;
        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(0, 5);
            lp = (n == 0) ? $urandom_range(0, DN - 2) : (n == 1) ? -1 : DN - 1;
            @(posedge clk); #1;
            send_frame(rand_frame(), rand_probs(), lp, 2, fa);
        end
        wait_results(frames_sent);
        repeat (5) @(negedge clk);
        check("total_start_pulses", start_cnt, frames_sent);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
